// File: rtl/td4_pkg.sv
// Shared constants and types for the TD4 switch input conditioning.
// Imported by the debouncer top and its per-channel sub-module.
package td4_pkg;

    localparam int SWITCH_WIDTH            = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One switch bit: pad synchroniser, saturating stability counter FSM and
// registered rise/fall pulses that coincide with the new debounced level.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// DB_STABLE   | synced matches level, cnt is 0
// DB_COUNTING | synced differs from level, cnt holds the mismatch edges seen
module debounce_channel
    import td4_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   mismatch;
    logic                   accept;

    db_state_t       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            level_nxt, rise_nxt, fall_nxt;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign mismatch = (synced != level);

    // cnt is 0 in DB_STABLE, so a single-cycle debounce accepts straight away
    assign accept = mismatch && (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q <= '0;
            state  <= DB_STABLE;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            level  <= level_nxt;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (accept) begin
            state_nxt = DB_STABLE;
            cnt_nxt   = '0;
            level_nxt = synced;
            rise_nxt  = synced;
            fall_nxt  = ~synced;
        end else begin
            case (state)
                DB_STABLE: begin
                    if (mismatch) begin
                        state_nxt = DB_COUNTING;
                        cnt_nxt   = CW'(1);
                    end
                end
                DB_COUNTING: begin
                    if (!mismatch) begin
                        state_nxt = DB_STABLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the raw DIP/push switches feeding the TD4 cpu switch port.
// Each bit is an independent debounce_channel; changed flags any edge.
module switch_debouncer
    import td4_pkg::*;
#(
    parameter int WIDTH           = SWITCH_WIDTH,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_switch,
    output logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall,
    output logic             changed
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clock (clock),
            .reset (reset),
            .raw   (raw_switch[i]),
            .level (switch[i]),
            .rise  (switch_rise[i]),
            .fall  (switch_fall[i])
        );
    end

    assign changed = |(switch_rise | switch_fall);

endmodule
